// File: rtl/equiv_sweep_checker_pkg.sv
// Shared sweep-order codes and checker FSM state encodings.
package equiv_sweep_checker_pkg;

    localparam logic [1:0] MODE_BIN_UP = 2'd0;
    localparam logic [1:0] MODE_GRAY   = 2'd1;
    localparam logic [1:0] MODE_BIN_DN = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/equiv_sweep_checker_pattern_gen.sv
// Combinational sweep index to stimulus vector mapping; zero latency.
// Unused mode code 3 falls back to binary-up order.
module sweep_pattern_gen
    import equiv_sweep_checker_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] idx_i,
    input  logic [1:0]       mode_i,
    output logic [WIDTH-1:0] vec_o
);

    always_comb begin
        case (mode_i)
            MODE_GRAY:   vec_o = idx_i ^ (idx_i >> 1);
            MODE_BIN_DN: vec_o = ~idx_i;
            default:     vec_o = idx_i;
        endcase
    end

endmodule

// File: rtl/equiv_sweep_checker.sv
// Sweeps all 2^WIDTH input vectors, one per clock, and compares DUT channels against channel 0.
// Accepted start to done rising is 2^WIDTH+1 cycles; all outputs are registered.
module equiv_sweep_checker
    import equiv_sweep_checker_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int NCH   = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] vec,
    input  logic [NCH-1:0]   dut_y,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [NCH-1:0]   fail_mask,
    output logic             first_fail_valid,
    output logic [WIDTH-1:0] first_fail_vec
);

    localparam logic [WIDTH-1:0] IDX_LAST = '1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] vec_q, vec_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]   mask_q, mask_d;
    logic             ffv_q, ffv_d;
    logic [WIDTH-1:0] ffvec_q, ffvec_d;

    logic             start_ok;
    logic [NCH-1:0]   diff;
    logic [WIDTH-1:0] gen_idx;
    logic [1:0]       gen_mode;
    logic [WIDTH-1:0] gen_vec;

    // One generator serves both the first vector of a sweep and every later step.
    assign start_ok = start && (state_q != S_RUN);
    assign gen_idx  = start_ok ? '0 : idx_q + 1'b1;
    assign gen_mode = start_ok ? mode : mode_q;
    assign diff     = dut_y ^ {NCH{dut_y[0]}};

    sweep_pattern_gen #(.WIDTH(WIDTH)) u_pattern_gen (
        .idx_i  (gen_idx),
        .mode_i (gen_mode),
        .vec_o  (gen_vec)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        ffv_d   = ffv_q;
        ffvec_d = ffvec_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    mode_d  = mode;
                    idx_d   = '0;
                    vec_d   = gen_vec;
                    cnt_d   = '0;
                    mask_d  = '0;
                    ffv_d   = 1'b0;
                    ffvec_d = '0;
                end
            end
            S_RUN: begin
                if (|diff) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    mask_d = mask_q | diff;
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffvec_d = vec_q;
                    end
                end
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                    vec_d = gen_vec;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            vec_q   <= '0;
            mode_q  <= MODE_BIN_UP;
            cnt_q   <= '0;
            mask_q  <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
        end
    end

    assign vec              = vec_q;
    assign busy             = (state_q == S_RUN);
    assign done             = (state_q == S_DONE);
    assign mismatch_cnt     = cnt_q;
    assign fail_mask        = mask_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;

endmodule

// File: doc/equiv_sweep_checker.md
Name: equiv_sweep_checker

Overview:
- Self-contained stimulus and check engine for equivalence-testing combinational implementations of one boolean function, e.g. structural, NAND-only and continuous-assignment versions.
- Drives every WIDTH-bit input vector in a selectable order, one vector per clock. Samples all NCH DUT outputs and compares channels 1..NCH-1 against channel 0 (golden).
- Accumulates mismatch statistics and signals completion. Sits in the bench/bring-up area and replaces free-running count registers.

Parameters:
- WIDTH, 3, number of DUT input bits; sweep length is 2^WIDTH vectors; legal range 1..16.
- NCH, 3, number of DUT output channels compared; legal range 2..8.
- CNT_W, 16, width of the mismatch counter; the counter saturates.

Ports:
- clk  input  1  single rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- mode  input  2  sweep order, latched on an accepted start: 0 binary up, 1 Gray, 2 binary down, 3 behaves as 0.
- vec  output  WIDTH  registered stimulus to the DUTs.
- dut_y  input  NCH  DUT outputs; bit 0 is golden.
- busy  output  1  high while in RUN.
- done  output  1  high in DONE; held until the next accepted start or rst.
- mismatch_cnt  output  CNT_W  number of vectors with any channel mismatch.
- fail_mask  output  NCH  sticky per-channel mismatch flags; bit 0 is always 0.
- first_fail_valid  output  1  high once any mismatch has been recorded.
- first_fail_vec  output  WIDTH  vec value at the first mismatch.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; vec=0; busy=0; done=0; mismatch_cnt=0; fail_mask=0; first_fail_valid=0; first_fail_vec=0.
  - rst has priority over start and over every other event.
  - rst asserted mid-sweep aborts the sweep at that edge with no partial done.
- States:
  - IDLE: vec held at 0.
  - RUN: sweep in progress.
  - DONE: vec holds the last applied vector.
- IDLE/DONE + start: at that edge go to RUN.
  - Latch mode; idx=0; vec=pattern(0).
  - Clear mismatch_cnt, fail_mask, first_fail_valid, first_fail_vec and done.
  - busy=1 from the next cycle.
- RUN, at every rising edge:
  - dut_y is the settled response to the current vec.
  - Compute per-channel diff[i] = dut_y[i] ^ dut_y[0] for i>=1.
  - If any diff bit is set:
    - mismatch_cnt increments, saturating at all-ones.
    - fail_mask |= diff.
    - If first_fail_valid=0, set first_fail_vec=vec and first_fail_valid=1.
  - If idx == 2^WIDTH-1: go to DONE (busy=0, done=1) and leave vec unchanged. Otherwise idx+=1 and vec=pattern(idx+1).
- Pattern mapping:
  - Binary up: idx.
  - Gray: idx ^ (idx>>1).
  - Binary down: ~idx (2^WIDTH-1-idx).
- Latency and counts:
  - Accepted start to done rising: exactly 2^WIDTH+1 cycles.
  - Exactly 2^WIDTH compares per sweep.
  - Every vector is applied exactly once per sweep; no wrap-around inside a sweep.
- start in RUN is ignored, with no restart and no effect on stats. start in DONE restarts immediately.
- mode changes outside an accepted start have no effect.
- All outputs are registered; there is no combinational path from dut_y to any output.
- Internal idx is WIDTH bits; the terminal compare uses the all-ones value, so no WIDTH+1 counter is needed.

Decomposition:
- Shared include file holds:
  - Mode constants: MODE_BIN_UP=0, MODE_GRAY=1, MODE_BIN_DN=2.
  - State encodings: S_IDLE, S_RUN, S_DONE.
- Sub-module sweep_pattern_gen: purely combinational idx+mode to vec mapping, parametrised by WIDTH, with its own unit bench.
- The FSM, compare logic and stats stay in equiv_sweep_checker.

Test Plan:
- Defaults, mode=0, three identical XOR-of-inputs DUTs; pulse start → vec steps 0..7, done high at cycle 9 after start, mismatch_cnt=0, fail_mask=3'b000, first_fail_valid=0.
- mode=1, WIDTH=3 → vec sequence 0,1,3,2,6,7,5,4; consecutive vectors differ in exactly 1 bit.
- Channel 2 DUT with a fault at input 3'b101 only, mode=2 → mismatch_cnt=1, fail_mask=3'b100, first_fail_vec=3'b101.
- Channel 1 inverted on all inputs, CNT_W=2 → mismatch_cnt saturates at 3; first_fail_vec=0 (mode 0); fail_mask=3'b010.
- Pulse start again at idx=4 → ignored, sweep ends normally. Then assert rst at idx=2 of a new sweep → next cycle IDLE, vec=0, busy=0, done=0, all stats 0.
- start asserted while in DONE with mode=3 → stats cleared the same edge, binary-up sweep reruns, done deasserted next cycle.
